vga_timing_gen: RTL and testbench

//  Parametrised VGA raster engine: pixel-rate divider, H/V counters, sync generation, framebuffer address out.

---
 rtl/vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// VGA raster engine. A clock divider produces one pixel tick every PIX_DIV
// clocks; horizontal/vertical counters advance on that tick and drive a
// two-stage pipeline:
//   stage 0 : issues the framebuffer address for the current raster position
//             and captures the timing flags (active, hsync, vsync, bar index,
//             first pixel) that belong to that position.
//   stage 1 : one tick later, samples the returned pixel data and presents
//             colours, syncs and the active flag together, so syncs and
//             colours are always aligned to the same pixel.
// A colour-bar generator can replace framebuffer data; the mode is latched
// only at the start of a frame so a frame is never half bars, half image.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high; clears all state
//   test_mode  in   1 = colour bars, 0 = framebuffer data
//   rgb_in     in   {R,G,B} returned by memory for the last mem_addr
//   mem_addr   out  {vcnt>>SCALE_SH, hcnt>>SCALE_SH} truncated to field widths
//   mem_rd_en  out  high while mem_addr carries an active-region address
//   VGA_RED / VGA_GREEN / VGA_BLUE   out  colour channels (0 in blanking)
//   VGA_HSYNC / VGA_VSYNC            out  syncs, active level = *_POL
//   sof        out  one-clock pulse when pixel (0,0) reaches the outputs
//   active     out  outputs currently carry a visible pixel
//
// Memory handshake: there is no ready/valid back-pressure. A read request is
// mem_rd_en=1 together with mem_addr, both updated on a pixel tick and held
// until the next tick; the request is always accepted, and rgb_in must carry
// the word for that address no later than PIX_DIV clocks after the request,
// which is the next tick, when stage 1 samples it.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PIX_DIV   = 2,
  parameter int   SCALE_SH  = 2,
  parameter int   ADDR_HW   = 8,
  parameter int   ADDR_VW   = 6,
  parameter int   COLOR_W   = 1,
  parameter int   BAR_SH    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       test_mode,
  input  logic [3*COLOR_W-1:0]       rgb_in,
  output logic [ADDR_VW+ADDR_HW-1:0] mem_addr,
  output logic                       mem_rd_en,
  output logic [COLOR_W-1:0]         VGA_RED,
  output logic [COLOR_W-1:0]         VGA_GREEN,
  output logic [COLOR_W-1:0]         VGA_BLUE,
  output logic                       VGA_HSYNC,
  output logic                       VGA_VSYNC,
  output logic                       sof,
  output logic                       active
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DIVW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PIX_DIV - 1);

  // Region bounds are stored as inclusive "last" values so that every
  // constant fits in the counter width even when a porch is zero.
  localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_LAST   = HCW'(H_ACTIVE - 1);
  localparam logic [HCW-1:0] H_SYNC_FIRST = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SYNC_LAST  = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_LAST   = VCW'(V_ACTIVE - 1);
  localparam logic [VCW-1:0] V_SYNC_FIRST = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SYNC_LAST  = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // Pixel-rate divider
  // ---------------------------------------------------------------------------
  logic [DIVW-1:0] div;
  logic            tick;

  // With div cleared by reset, the first tick lands on the PIX_DIV-th clock
  // after reset is released. For PIX_DIV=1 div stays 0 and every clock ticks.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0 decode of the current raster position
  // ---------------------------------------------------------------------------
  logic               in_act_c;
  logic               hs_c;
  logic               vs_c;
  logic               first_c;
  logic [2:0]         bar_c;
  logic [ADDR_HW-1:0] addr_h_c;
  logic [ADDR_VW-1:0] addr_v_c;

  assign in_act_c = (hcnt <= H_ACT_LAST) && (vcnt <= V_ACT_LAST);
  assign hs_c     = (hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST);
  assign vs_c     = (vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST);
  assign first_c  = (hcnt == '0) && (vcnt == '0);

  // Bar index: which 2^BAR_SH-wide column the pixel sits in, modulo 8.
  assign bar_c    = 3'(hcnt >> BAR_SH);

  // Pixel replication: each framebuffer word covers 2^SCALE_SH x 2^SCALE_SH
  // screen pixels. The casts truncate (or zero-extend) to the field widths.
  assign addr_h_c = ADDR_HW'(hcnt >> SCALE_SH);
  assign addr_v_c = ADDR_VW'(vcnt >> SCALE_SH);

  // ---------------------------------------------------------------------------
  // Stage 0 registers: address issue plus flags delayed alongside the read
  // ---------------------------------------------------------------------------
  logic       act0;
  logic       hs0;
  logic       vs0;
  logic       first0;
  logic [2:0] bar0;
  logic       mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      act0     <= 1'b0;
      hs0      <= 1'b0;
      vs0      <= 1'b0;
      first0   <= 1'b0;
      bar0     <= '0;
      mode_q   <= 1'b0;
    end else if (tick) begin
      act0   <= in_act_c;
      hs0    <= hs_c;
      vs0    <= vs_c;
      first0 <= first_c;
      bar0   <= bar_c;
      // The address only moves inside the active region; during blanking it
      // holds the last visible address so the memory sees no spurious change.
      if (in_act_c) begin
        mem_addr <= {addr_v_c, addr_h_c};
      end
      // Mode is latched only as pixel (0,0) is issued. Stage 1 of that tick
      // still shows the previous frame's last (blanked) pixel, so the switch
      // is invisible until the new frame's first pixel.
      if (first_c) begin
        mode_q <= test_mode;
      end
    end
  end

  // The read strobe is exactly the delayed active flag.
  assign mem_rd_en = act0;

  // ---------------------------------------------------------------------------
  // Stage 1 pixel selection
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (act0) begin
      if (mode_q) begin
        pix_r = {COLOR_W{bar0[2]}};
        pix_g = {COLOR_W{bar0[1]}};
        pix_b = {COLOR_W{bar0[0]}};
      end else begin
        pix_r = rgb_in[3*COLOR_W-1 -: COLOR_W];
        pix_g = rgb_in[2*COLOR_W-1 -: COLOR_W];
        pix_b = rgb_in[COLOR_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers: everything visible on the pins updates on one edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
      VGA_HSYNC <= ~HSYNC_POL;
      VGA_VSYNC <= ~VSYNC_POL;
      active    <= 1'b0;
      sof       <= 1'b0;
    end else begin
      // Evaluated every clock so the pulse lasts exactly one clock.
      sof <= tick & first0;
      if (tick) begin
        VGA_RED   <= pix_r;
        VGA_GREEN <= pix_g;
        VGA_BLUE  <= pix_b;
        VGA_HSYNC <= hs0 ? HSYNC_POL : ~HSYNC_POL;
        VGA_VSYNC <= vs0 ? VSYNC_POL : ~VSYNC_POL;
        active    <= act0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen with a shrunken raster (24 x 10 pixel frame,
// PIX_DIV=2) so several frames fit in a short run.
//   - a generator process pushes, every clock, the expected pin state derived
//     from the raster position implied by clocks since reset release;
//   - a monitor process pops one entry every falling edge and compares it
//     with the DUT pins;
//   - a directed checker measures sync/active/sof intervals against
//     hand-computed clock counts and probes specific address cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Reduced geometry
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int HT = HA + HF + HS + HB;           // 24 px/line
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int VT = VA + VF + VS + VB;           // 10 lines
  localparam int PD = 2, SSH = 1, AHW = 2, AVW = 2, CW = 2, BSH = 1;
  localparam int AW = AVW + AHW;
  localparam int RGBW = 3 * CW;
  localparam int FRAME_PX = HT * VT;               // 240
  localparam int FRAME_CLKS = FRAME_PX * PD;       // 480

  localparam logic [RGBW-1:0] CONST_RGB = 6'b11_00_11;  // R=3 G=0 B=3

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            reset;
  logic            test_mode;
  logic            mem_const_en;
  logic [RGBW-1:0] rgb_in;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_en;
  logic [CW-1:0]   vga_red, vga_green, vga_blue;
  logic            vga_hsync, vga_vsync, sof, active;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .PIX_DIV(PD), .SCALE_SH(SSH), .ADDR_HW(AHW), .ADDR_VW(AVW),
    .COLOR_W(CW), .BAR_SH(BSH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .test_mode (test_mode),
    .rgb_in    (rgb_in),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .VGA_RED   (vga_red),
    .VGA_GREEN (vga_green),
    .VGA_BLUE  (vga_blue),
    .VGA_HSYNC (vga_hsync),
    .VGA_VSYNC (vga_vsync),
    .sof       (sof),
    .active    (active)
  );

  // ---------------------------------------------------------------------------
  // Framebuffer model and reference helpers
  // ---------------------------------------------------------------------------
  function automatic logic [RGBW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, a[1:0]} ^ 6'b101101;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int unsigned h, input int unsigned v);
    return {AVW'(v >> SSH), AHW'(h >> SSH)};
  endfunction

  function automatic logic [RGBW-1:0] bar_word(input int unsigned h);
    logic [2:0] b;
    b = 3'(h >> BSH);
    return {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
  endfunction

  // Memory answers combinationally, well inside the one-tick budget.
  assign rgb_in = mem_const_en ? CONST_RGB : mem_word(mem_addr);

  // ---------------------------------------------------------------------------
  // Scoreboard: expected pin state, one entry per clock
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rd_en;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          hs;
    logic          vs;
    logic          sof;
    logic          act;
  } obs_t;

  localparam int OW = $bits(obs_t);
  logic [OW-1:0] exp_q[$];

  int unsigned rel_cnt = 0;   // clocks since reset release
  logic        exp_mode = 1'b0;
  obs_t        st;

  always @(posedge clk) begin
    int unsigned k, p, h, v, p0, h0, v0;
    logic        tick_e, act_e;
    if (reset) begin
      rel_cnt  = 0;
      exp_mode = 1'b0;
      st       = '0;
      st.hs    = 1'b1;
      st.vs    = 1'b1;
    end else begin
      rel_cnt++;
      tick_e = (rel_cnt % PD) == 0;
      k      = rel_cnt / PD;
      st.sof = 1'b0;
      if (tick_e) begin
        // Pins show the pixel whose address went out one tick earlier.
        if (k >= 2) begin
          p      = k - 2;
          h      = p % HT;
          v      = (p / HT) % VT;
          act_e  = (h < HA) && (v < VA);
          st.act = act_e;
          st.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
          st.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
          st.sof = (p % FRAME_PX) == 0;
          {st.r, st.g, st.b} = '0;
          if (act_e) begin
            if (exp_mode)          {st.r, st.g, st.b} = bar_word(h);
            else if (mem_const_en) {st.r, st.g, st.b} = CONST_RGB;
            else                   {st.r, st.g, st.b} = mem_word(addr_of(h, v));
          end
        end
        // Address issue for the position being entered on this tick.
        p0       = k - 1;
        h0       = p0 % HT;
        v0       = (p0 / HT) % VT;
        st.rd_en = (h0 < HA) && (v0 < VA);
        if (st.rd_en) st.addr = addr_of(h0, v0);
        if ((p0 % FRAME_PX) == 0) exp_mode = test_mode;
      end
    end
    exp_q.push_back(st);
  end

  // Monitor: the DUT presents a pin state every clock.
  always @(negedge clk) begin
    obs_t got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {mem_addr, mem_rd_en, vga_red, vga_green, vga_blue,
             vga_hsync, vga_vsync, sof, active};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pins t=%0t rel=%0d: got addr=%h rd=%b rgb=%h/%h/%h hs=%b vs=%b sof=%b act=%b, expected addr=%h rd=%b rgb=%h/%h/%h hs=%b vs=%b sof=%b act=%b",
                 $time, rel_cnt, got.addr, got.rd_en, got.r, got.g, got.b, got.hs, got.vs, got.sof, got.act,
                 exp.addr, exp.rd_en, exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.sof, exp.act);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed interval / address checks (hand-computed clock counts)
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int unsigned got_v, input int unsigned exp_v);
    n_vec++;
    if (got_v != exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got_v, exp_v);
    end
  endtask

  logic        p_hs = 1'b1, p_vs = 1'b1, p_act = 1'b0, p_sof = 1'b0;
  bit          have_hs = 0, have_vs = 0, have_act = 0, have_sof = 0;
  int unsigned t_hs = 0, t_vs = 0, t_act = 0, t_sof = 0;

  always @(negedge clk) begin
    if (reset) begin
      have_hs = 0; have_vs = 0; have_act = 0; have_sof = 0;
      p_hs = 1'b1; p_vs = 1'b1; p_act = 1'b0; p_sof = 1'b0;
    end else begin
      // hsync: 24 px * 2 clk period, 3 px * 2 clk low
      if (p_hs && !vga_hsync) begin
        if (have_hs) check("hsync_period", cyc - t_hs, 48);
        t_hs = cyc; have_hs = 1;
      end
      if (!p_hs && vga_hsync && have_hs) check("hsync_low_width", cyc - t_hs, 6);
      // vsync: 240 px * 2 clk period, 2 lines * 48 clk low
      if (p_vs && !vga_vsync) begin
        if (have_vs) check("vsync_period", cyc - t_vs, 480);
        t_vs = cyc; have_vs = 1;
      end
      if (!p_vs && vga_vsync && have_vs) check("vsync_low_width", cyc - t_vs, 96);
      // active: 16 px * 2 clk per line
      if (!p_act && active) begin
        t_act = cyc; have_act = 1;
      end
      if (p_act && !active && have_act) check("active_width", cyc - t_act, 32);
      // sof: pixel (0,0) reaches pins two ticks (4 clks) after release
      if (!p_sof && sof) begin
        if (have_sof) check("sof_period", cyc - t_sof, 480);
        else          check("sof_after_release", rel_cnt, 4);
        t_sof = cyc; have_sof = 1;
      end
      if (p_sof && !sof && have_sof) check("sof_width", cyc - t_sof, 1);
      // Tick 105 issues position h=8,v=4 -> {v>>1, h>>1} = {2, 4 mod 4} = 4'b1000
      if (rel_cnt == 210) begin
        check("addr_h8_v4", mem_addr, 4'b1000);
        check("rd_en_h8_v4", mem_rd_en, 1);
      end
      // Tick 113 is h=16: no read, address holds h=15,v=4 -> 4'b1011
      if (rel_cnt == 226) begin
        check("addr_held_h16", mem_addr, 4'b1011);
        check("rd_en_h16", mem_rd_en, 0);
      end
      p_hs = vga_hsync; p_vs = vga_vsync; p_act = active; p_sof = sof;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    wait_clks(n);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    test_mode    = 1'b0;
    mem_const_en = 1'b0;
    apply_reset(5);

    // Frames 0-1 show address-derived framebuffer data; bars requested
    // mid-frame 1 must not appear until frame 2 starts.
    wait_clks(FRAME_CLKS + 100);
    test_mode = 1'b1;

    // Mid-frame 2 (bars): switch the memory to a constant word and drop
    // test_mode; frame 3 must show the constant word only where active.
    wait_clks(FRAME_CLKS);
    mem_const_en = 1'b1;
    test_mode    = 1'b0;

    // Mid-frame 3: reset in the middle of a line, then run two more frames.
    wait_clks(FRAME_CLKS + 13);
    apply_reset(3);
    mem_const_en = 1'b0;
    wait_clks(2 * FRAME_CLKS + 50);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
